multicycle_control: RTL and testbench
=====================================

# multicycle_control

Finite-state controller that sequences the multi-cycle MIPS datapath: instruction fetch, decode, execute, memory access and write-back over several clocks, driving a single shared memory port, ALU and register file. It replaces single-cycle opcode decode in the multi-cycle build. It accepts a memory-ready handshake so fetch and data accesses can stall.

## Interface
- MEM_WAIT_EN, 1, when 0 `mem_ready` is ignored and treated as 1.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  opcode from the instruction register, IR[31:26].
- mem_ready  in  1  memory port completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU Zero in the datapath.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead, MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = use funct field.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state code, for debug and verification.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- States and encodings:
  - FETCH = 0
  - DECODE = 1
  - MEMADR = 2
  - MEMRD = 3
  - MEMWB = 4
  - MEMWR = 5
  - EXEC = 6
  - RTYPE_WB = 7
  - BRANCH = 8
  - JUMP = 9
  - ADDI_EX = 10
  - ADDI_WB = 11
  - Codes 12–15 are unused and return to FETCH.
- Outputs are a Moore decode of `state`. Exception: in the memory states, the completion strobes are ANDed with `mem_ready`. Any output not listed for a state is 0.
- FETCH:
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - Asserts IRWrite and PCWrite only when mem_ready=1.
  - Goes to DECODE when mem_ready=1, otherwise stays in FETCH.
- DECODE:
  - Asserts ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target computed into ALUOut).
  - Next state by opcode:
    - 000000 → EXEC
    - 100011 or 101011 → MEMADR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → ADDI_EX
    - any other opcode → FETCH, with illegal_op=1 and instr_done=1.
- MEMADR: asserts ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if op=100011, MEMWR if op=101011.
- MEMRD: asserts MemRead=1, IorD=1. Goes to MEMWB when mem_ready=1, otherwise stays.
- MEMWB: asserts RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Goes to FETCH.
- MEMWR: asserts MemWrite=1, IorD=1. When mem_ready=1, asserts instr_done=1 and goes to FETCH; otherwise stays.
- EXEC: asserts ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RTYPE_WB.
- RTYPE_WB: asserts RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Goes to FETCH.
- BRANCH: asserts ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Goes to FETCH.
- JUMP: asserts PCWrite=1, PCSource=10, instr_done=1. Goes to FETCH.
- ADDI_EX: asserts ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDI_WB.
- ADDI_WB: asserts RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Goes to FETCH.
- `op` is sampled only in DECODE and MEMADR. It must remain stable from the IR load until the instruction completes.

## Timing
- Reset:
  - While rst=1, state=FETCH and every output is forced to 0, including the FETCH strobes.
  - The first cycle after rst deasserts is FETCH with its normal outputs.
- rst asserted mid-instruction aborts immediately. No write strobe is asserted on or after the asserting edge.
- Cycle counts with mem_ready=1 throughout:
  - beq, j: 3 cycles
  - R-type, sw, addi: 4 cycles
  - lw: 5 cycles
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. While stalled, the address and strobe outputs are held constant.
- mem_ready has no effect in any other state.
- instr_done and illegal_op are combinational from state, op and mem_ready. They are high for exactly one cycle per instruction.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (R_TYPE, LW, SW, BEQ, J, ADDI)
  - ALUOp encodings
  - ALUSrcB and PCSource select encodings
  - the 4-bit state encoding listed above.
- Single module. The next-state logic and the output decode are separate always blocks; no sub-module.

## Test plan
- Reset: hold rst=1 for 3 cycles → all outputs 0, state=0. Release → FETCH with MemRead=1, IRWrite=1, PCWrite=1.
- op=000000, mem_ready=1 → state sequence 0,1,6,7,0. RegWrite=1 and RegDst=1 in state 7. instr_done pulses once.
- op=100011, mem_ready=0 for 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0. IorD=1 throughout state 3. RegWrite=1 with MemtoReg=1 only in state 4.
- op=101011, with mem_ready low for 1 cycle in FETCH and 1 cycle in MEMWR:
  - sequence 0,0,1,2,5,5,0
  - IRWrite=0 in the first FETCH cycle
  - instr_done only in the second cycle of state 5.
- Branch, jump, addi back to back (op=000100, then 000010, then 001000):
  - BRANCH: PCWriteCond=1, PCSource=01, ALUOp=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDI_WB: RegWrite=1, RegDst=0.
- Illegal opcode and mid-instruction reset:
  - op=111111 → sequence 0,1,0 with illegal_op=1 in state 1 and no write strobes.
  - Assert rst during state 3 of a lw → outputs 0 immediately. After release, state=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes,
// datapath select encodings and the controller state encoding.
package mips_pkg;

  // Opcodes (IR[31:26]) understood by the controller
  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] J      = 6'b000010;
  localparam logic [5:0] ADDI   = 6'b001000;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B input select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states; codes 12-15 are unused
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXEC     = 4'd6,
    RTYPE_WB = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11
  } state_t;

  // True for every opcode the controller can sequence
  function automatic logic is_legal(input logic [5:0] opc);
    return (opc == R_TYPE) || (opc == LW) || (opc == SW) ||
           (opc == BEQ) || (opc == J) || (opc == ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and the datapath.
interface multicycle_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;

  // Controller side
  modport master (
    input  op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, instr_done, illegal_op
  );

  // Datapath side
  modport slave (
    output op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: sequences fetch/decode/execute/memory/
// write-back and drives the shared memory port, ALU and register file.
module multicycle_control
  import mips_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  state_t state_q;
  state_t state_d;
  logic   rdy;

  // Without memory wait support every access completes in one cycle
  assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = rdy ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          R_TYPE:  state_d = EXEC;
          LW, SW:  state_d = MEMADR;
          BEQ:     state_d = BRANCH;
          J:       state_d = JUMP;
          ADDI:    state_d = ADDI_EX;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (bus.op == LW)      state_d = MEMRD;
        else if (bus.op == SW) state_d = MEMWR;
        else                   state_d = FETCH;
      end
      MEMRD:    state_d = rdy ? MEMWB : MEMRD;
      MEMWB:    state_d = FETCH;
      MEMWR:    state_d = rdy ? FETCH : MEMWR;
      EXEC:     state_d = RTYPE_WB;
      RTYPE_WB: state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      ADDI_EX:  state_d = ADDI_WB;
      ADDI_WB:  state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Output decode; rst gates everything so no strobe survives the reset edge
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = SRCB_REG;
    bus.ALUOp       = ALUOP_ADD;
    bus.PCSource    = PCSRC_ALU;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.state       = state_q;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          bus.MemRead  = 1'b1;
          bus.ALUSrcB  = SRCB_FOUR;
          bus.IRWrite  = rdy;
          bus.PCWrite  = rdy;
        end
        DECODE: begin
          bus.ALUSrcB = SRCB_IMM_SH2;
          if (!is_legal(bus.op)) begin
            bus.illegal_op = 1'b1;
            bus.instr_done = 1'b1;
          end
        end
        MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
        end
        MEMRD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        MEMWB: begin
          bus.RegWrite   = 1'b1;
          bus.MemtoReg   = 1'b1;
          bus.instr_done = 1'b1;
        end
        MEMWR: begin
          bus.MemWrite   = 1'b1;
          bus.IorD       = 1'b1;
          bus.instr_done = rdy;
        end
        EXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = ALUOP_FUNCT;
        end
        RTYPE_WB: begin
          bus.RegWrite   = 1'b1;
          bus.RegDst     = 1'b1;
          bus.instr_done = 1'b1;
        end
        BRANCH: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = ALUOP_SUB;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = PCSRC_ALUOUT;
          bus.instr_done  = 1'b1;
        end
        JUMP: begin
          bus.PCWrite    = 1'b1;
          bus.PCSource   = PCSRC_JUMP;
          bus.instr_done = 1'b1;
        end
        ADDI_EX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
        end
        ADDI_WB: begin
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model
// expands each opcode plus stall counts into the expected per-cycle trace.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  multicycle_control_if b();

  multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  logic [5:0]  cur_op;
  logic [63:0] dut_seq;
  int          dut_len;
  int          done_cnt;
  int          ill_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] dut_vec();
    return {b.PCWrite, b.PCWriteCond, b.IorD, b.MemRead, b.MemWrite, b.IRWrite,
            b.MemtoReg, b.RegDst, b.RegWrite, b.ALUSrcA, b.ALUSrcB, b.ALUOp,
            b.PCSource, b.state, b.instr_done, b.illegal_op};
  endfunction

  function automatic logic legal(input logic [5:0] o);
    return o == 6'd0 || o == 6'd35 || o == 6'd43 || o == 6'd4 || o == 6'd2 || o == 6'd8;
  endfunction

  // Expected control word for one cycle in state s with mem_ready r
  function automatic logic [21:0] exp_vec(input logic [3:0] s, input logic r, input logic [5:0] o);
    logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, done, ill;
    logic [1:0] sb, aop, pcs;
    {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, done, ill} = '0;
    sb = 2'd0; aop = 2'd0; pcs = 2'd0;
    case (s)
      4'd0:  begin mrd = 1; sb = 2'd1; irw = r; pcw = r; end
      4'd1:  begin sb = 2'd3; ill = !legal(o); done = !legal(o); end
      4'd2:  begin sa = 1; sb = 2'd2; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; done = 1; end
      4'd5:  begin mwr = 1; iord = 1; done = r; end
      4'd6:  begin sa = 1; aop = 2'd2; end
      4'd7:  begin rw = 1; rdst = 1; done = 1; end
      4'd8:  begin sa = 1; aop = 2'd1; pcc = 1; pcs = 2'd1; done = 1; end
      4'd9:  begin pcw = 1; pcs = 2'd2; done = 1; end
      4'd10: begin sa = 1; sb = 2'd2; end
      4'd11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, pcs, s, done, ill};
  endfunction

  // One cycle: drive mem_ready, compare outputs, advance to next negedge
  task automatic step(input logic [3:0] s, input logic r);
    b.mem_ready = r;
    #1;
    chk($sformatf("out_st%0d_op%0h_rdy%0d", s, cur_op, r), {42'd0, dut_vec()}, {42'd0, exp_vec(s, r, cur_op)});
    dut_seq = {dut_seq[59:0], b.state};
    dut_len++;
    if (b.instr_done) done_cnt++;
    if (b.illegal_op) ill_cnt++;
    @(negedge clk);
  endtask

  // Expand an instruction into its expected state trace and run it
  task automatic run_instr(input logic [5:0] o, input int fs, input int ms);
    logic [4:0] q[$];
    q = {};
    for (int i = 0; i < fs; i++) q.push_back({1'b0, 4'd0});
    q.push_back({1'b1, 4'd0});
    q.push_back({1'($urandom), 4'd1});
    case (o)
      6'd0:  begin q.push_back({1'($urandom), 4'd6}); q.push_back({1'($urandom), 4'd7}); end
      6'd35: begin
        q.push_back({1'($urandom), 4'd2});
        for (int i = 0; i < ms; i++) q.push_back({1'b0, 4'd3});
        q.push_back({1'b1, 4'd3});
        q.push_back({1'($urandom), 4'd4});
      end
      6'd43: begin
        q.push_back({1'($urandom), 4'd2});
        for (int i = 0; i < ms; i++) q.push_back({1'b0, 4'd5});
        q.push_back({1'b1, 4'd5});
      end
      6'd4:  q.push_back({1'($urandom), 4'd8});
      6'd2:  q.push_back({1'($urandom), 4'd9});
      6'd8:  begin q.push_back({1'($urandom), 4'd10}); q.push_back({1'($urandom), 4'd11}); end
      default: ;
    endcase
    cur_op = o;
    b.op = o;
    dut_seq = '0; dut_len = 0; done_cnt = 0; ill_cnt = 0;
    foreach (q[i]) step(q[i][3:0], q[i][4]);
    chk($sformatf("done_once_op%0h", o), 64'(done_cnt), 64'd1);
    chk($sformatf("illegal_op%0h", o), 64'(ill_cnt), legal(o) ? 64'd0 : 64'd1);
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] tbl[6];
    logic [5:0] o;
    tbl = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8};
    if ($urandom_range(0, 9) == 0) begin
      do o = 6'($urandom); while (legal(o));
      return o;
    end
    return tbl[$urandom_range(0, 5)];
  endfunction

  initial begin
    b.op = 6'd0;
    b.mem_ready = 1'b1;
    cur_op = 6'd0;
    dut_seq = '0; dut_len = 0; done_cnt = 0; ill_cnt = 0;

    // Reset held for three cycles: everything at zero
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("reset_outputs", {42'd0, dut_vec()}, 64'd0);
    end
    rst = 1'b0;

    // Directed sequences with hand-derived traces and lengths
    run_instr(6'b000000, 0, 0);
    chk("seq_rtype", dut_seq, 64'h0167);
    chk("len_rtype", 64'(dut_len), 64'd4);
    run_instr(6'b100011, 0, 2);
    chk("seq_lw_stall", dut_seq, 64'h0123334);
    chk("len_lw_stall", 64'(dut_len), 64'd7);
    run_instr(6'b101011, 1, 1);
    chk("seq_sw_stall", dut_seq, 64'h001255);
    chk("len_sw_stall", 64'(dut_len), 64'd6);
    run_instr(6'b000100, 0, 0);
    chk("seq_beq", dut_seq, 64'h018);
    run_instr(6'b000010, 0, 0);
    chk("seq_j", dut_seq, 64'h019);
    run_instr(6'b001000, 0, 0);
    chk("seq_addi", dut_seq, 64'h01AB);
    chk("len_addi", 64'(dut_len), 64'd4);
    run_instr(6'b100011, 0, 0);
    chk("len_lw", 64'(dut_len), 64'd5);
    run_instr(6'b111111, 0, 0);
    chk("seq_illegal", dut_seq, 64'h01);

    // Reset while a load is waiting in MEMRD
    cur_op = 6'b100011;
    b.op = cur_op;
    step(4'd0, 1'b1);
    step(4'd1, 1'b1);
    step(4'd2, 1'b1);
    b.mem_ready = 1'b0;
    #1;
    chk("pre_abort_state", 64'(b.state), 64'd3);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {42'd0, dut_vec()}, 64'd0);
    @(negedge clk);
    #1;
    chk("abort_hold_outputs", {42'd0, dut_vec()}, 64'd0);
    rst = 1'b0;
    #1;
    chk("after_abort_state", 64'(b.state), 64'd0);

    // Randomized instruction stream with random stall counts
    for (int n = 0; n < 300; n++) begin
      logic [5:0] o;
      o = rand_op();
      run_instr(o, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
